// File: rtl/blink_frame_ctrl_pkg.sv
// Shared mode codes and FSM state encoding for the frame-synchronous blink controller.
package blink_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_STEADY = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_BURST  = 2'b11;

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_STEADY    = 3'd1,
        S_BLINK_ON  = 3'd2,
        S_BLINK_OFF = 3'd3,
        S_BURST_ON  = 3'd4,
        S_BURST_OFF = 3'd5
    } state_t;

    function automatic logic state_lit(input state_t s);
        return (s == S_STEADY) || (s == S_BLINK_ON) || (s == S_BURST_ON);
    endfunction

endpackage

// File: rtl/blink_frame_ctrl_if.sv
// Command channel of the blink controller: valid/ready handshake plus mode and period fields.
interface blink_frame_ctrl_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [1:0]           cfg_mode;
    logic [CNT_WIDTH-1:0] cfg_on;
    logic [CNT_WIDTH-1:0] cfg_off;
    logic [3:0]           cfg_burst;

    modport master (
        output cfg_valid, cfg_mode, cfg_on, cfg_off, cfg_burst,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_on, cfg_off, cfg_burst,
        output cfg_ready
    );
endinterface

// File: rtl/blink_frame_ctrl_cfg_shadow_reg.sv
// Command shadow register: accepts one command, holds it pending until the next frame tick.
// Ready is low from the cycle after acceptance until the cycle after the command is applied.
module cfg_shadow_reg
    import blink_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int DEF_ON    = 30,
    parameter int DEF_OFF   = 30
) (
    input  logic                 i_pclk,
    input  logic                 i_rst_n,
    input  logic                 tick,
    blink_frame_ctrl_if.slave    cfg,
    output logic                 apply,
    output logic [1:0]           sh_mode,
    output logic [CNT_WIDTH-1:0] sh_on,
    output logic [CNT_WIDTH-1:0] sh_off,
    output logic [3:0]           sh_burst
);

    logic pending;

    assign cfg.cfg_ready = ~pending;
    // pending is still 0 in the acceptance cycle, so a same-cycle tick cannot apply it
    assign apply         = tick & pending;

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending  <= 1'b0;
            sh_mode  <= MODE_OFF;
            sh_on    <= CNT_WIDTH'(DEF_ON);
            sh_off   <= CNT_WIDTH'(DEF_OFF);
            sh_burst <= 4'd0;
        end else if (cfg.cfg_valid && !pending) begin
            pending  <= 1'b1;
            sh_mode  <= cfg.cfg_mode;
            sh_on    <= cfg.cfg_on;
            sh_off   <= cfg.cfg_off;
            sh_burst <= cfg.cfg_burst;
        end else if (apply) begin
            pending  <= 1'b0;
        end
    end

endmodule

// File: rtl/blink_frame_ctrl.sv
// Frame-synchronous blink flag generator; FSM advances only on the vblank rising edge.
// Outputs change 1 clock after the tick; commands wait in the shadow register (ready low) until then.
module blink_frame_ctrl
    import blink_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int DEF_ON    = 30,
    parameter int DEF_OFF   = 30
) (
    input  logic              i_pclk,
    input  logic              i_rst_n,
    input  logic              i_vblnk,
    blink_frame_ctrl_if.slave cfg,
    output logic              o_blink,
    output logic              o_frame_tick,
    output logic              o_done
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic                 vblnk_q;
    logic                 tick;
    logic                 apply;
    logic [1:0]           sh_mode;
    logic [CNT_WIDTH-1:0] sh_on;
    logic [CNT_WIDTH-1:0] sh_off;
    logic [3:0]           sh_burst;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0] on_len, on_len_nxt;
    logic [CNT_WIDTH-1:0] off_len, off_len_nxt;
    logic [3:0]           burst_rem, burst_rem_nxt;
    logic                 done_nxt;

    assign tick = i_vblnk & ~vblnk_q;

    cfg_shadow_reg #(
        .CNT_WIDTH (CNT_WIDTH),
        .DEF_ON    (DEF_ON),
        .DEF_OFF   (DEF_OFF)
    ) u_shadow (
        .i_pclk   (i_pclk),
        .i_rst_n  (i_rst_n),
        .tick     (tick),
        .cfg      (cfg),
        .apply    (apply),
        .sh_mode  (sh_mode),
        .sh_on    (sh_on),
        .sh_off   (sh_off),
        .sh_burst (sh_burst)
    );

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        on_len_nxt    = on_len;
        off_len_nxt   = off_len;
        burst_rem_nxt = burst_rem;
        done_nxt      = 1'b0;
        if (apply) begin
            // a new command wins over any phase change due on this tick
            cnt_nxt       = '0;
            on_len_nxt    = (sh_on  == '0) ? ONE : sh_on;
            off_len_nxt   = (sh_off == '0) ? ONE : sh_off;
            burst_rem_nxt = sh_burst;
            case (sh_mode)
                MODE_STEADY: state_nxt = S_STEADY;
                MODE_BLINK:  state_nxt = S_BLINK_ON;
                MODE_BURST: begin
                    if (sh_burst == 4'd0) begin
                        state_nxt = S_OFF;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_BURST_ON;
                    end
                end
                default:     state_nxt = S_OFF;
            endcase
        end else if (tick) begin
            case (state)
                S_BLINK_ON, S_BURST_ON: begin
                    if (cnt + ONE == on_len) begin
                        state_nxt = (state == S_BLINK_ON) ? S_BLINK_OFF : S_BURST_OFF;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt + ONE;
                    end
                end
                S_BLINK_OFF: begin
                    if (cnt + ONE == off_len) begin
                        state_nxt = S_BLINK_ON;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt + ONE;
                    end
                end
                S_BURST_OFF: begin
                    if (cnt + ONE == off_len) begin
                        cnt_nxt       = '0;
                        burst_rem_nxt = burst_rem - 4'd1;
                        if (burst_rem == 4'd1) begin
                            state_nxt = S_OFF;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_BURST_ON;
                        end
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vblnk_q      <= 1'b0;
            state        <= S_OFF;
            cnt          <= '0;
            on_len       <= CNT_WIDTH'(DEF_ON);
            off_len      <= CNT_WIDTH'(DEF_OFF);
            burst_rem    <= 4'd0;
            o_blink      <= 1'b0;
            o_frame_tick <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            vblnk_q      <= i_vblnk;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            on_len       <= on_len_nxt;
            off_len      <= off_len_nxt;
            burst_rem    <= burst_rem_nxt;
            o_blink      <= state_lit(state_nxt);
            o_frame_tick <= tick;
            o_done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_blink_frame_ctrl.sv
// Bench for blink_frame_ctrl: per-cycle reference model, vector table, hand sequences, random traffic.
module tb_blink_frame_ctrl;
    import blink_pkg::*;

    localparam int CW = 8;

    logic i_pclk = 1'b0;
    logic i_rst_n;
    logic i_vblnk;
    logic o_blink, o_frame_tick, o_done;

    blink_frame_ctrl_if #(.CNT_WIDTH(CW)) cfg ();

    blink_frame_ctrl #(.CNT_WIDTH(CW), .DEF_ON(30), .DEF_OFF(30)) dut (
        .i_pclk       (i_pclk),
        .i_rst_n      (i_rst_n),
        .i_vblnk      (i_vblnk),
        .cfg          (cfg),
        .o_blink      (o_blink),
        .o_frame_tick (o_frame_tick),
        .o_done       (o_done)
    );

    always #5 i_pclk = ~i_pclk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: command applied at frame k=0, level derived from k and the periods
    bit m_vq, m_pend;
    int sh_mode, sh_on, sh_off, sh_burst;
    int a_mode, a_on, a_off, a_burst, k;
    bit e_blink, e_tick, e_done;

    bit rec[$];
    int done_frame, done_cnt;

    typedef struct {
        int        mode;
        int        on;
        int        off;
        int        burst;
        bit [11:0] pat;
        int        done_at;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_vq = 0; m_pend = 0;
        sh_mode = 0; sh_on = 30; sh_off = 30; sh_burst = 0;
        a_mode = 0; a_on = 30; a_off = 30; a_burst = 0; k = 0;
        e_blink = 0; e_tick = 0; e_done = 0;
    endfunction

    function automatic bit model_level();
        int p;
        p = a_on + a_off;
        case (a_mode)
            1: return 1'b1;
            2: return (k % p) < a_on;
            3: return (k < a_burst * p) && ((k % p) < a_on);
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        bit tick, acc, apply;
        acc = 0;
        if (!i_rst_n) begin
            model_reset();
        end else begin
            tick   = i_vblnk && !m_vq;
            acc    = cfg.cfg_valid && !m_pend;
            apply  = tick && m_pend;
            e_tick = tick;
            e_done = 0;
            if (tick) begin
                if (apply) begin
                    a_mode  = sh_mode;
                    a_on    = (sh_on  == 0) ? 1 : sh_on;
                    a_off   = (sh_off == 0) ? 1 : sh_off;
                    a_burst = sh_burst;
                    k       = 0;
                end else begin
                    k++;
                end
                e_blink = model_level();
                e_done  = (a_mode == 3) && (k == a_burst * (a_on + a_off));
            end
            if (apply) m_pend = 0;
            if (acc) begin
                m_pend   = 1;
                sh_mode  = int'(cfg.cfg_mode);
                sh_on    = int'(cfg.cfg_on);
                sh_off   = int'(cfg.cfg_off);
                sh_burst = int'(cfg.cfg_burst);
            end
            m_vq = i_vblnk;
        end
        @(posedge i_pclk);
        #1;
        if (acc) cfg.cfg_valid = 1'b0;
        check("blink", o_blink, e_blink);
        check("frame_tick", o_frame_tick, e_tick);
        check("done", o_done, e_done);
        check("ready", cfg.cfg_ready, !m_pend);
        if (o_frame_tick) rec.push_back(o_blink);
        if (o_done) begin
            done_cnt++;
            if (o_frame_tick) done_frame = rec.size() - 1;
        end
    endtask

    task automatic issue(input int mode, input int on, input int off, input int burst);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_mode  = 2'(mode);
        cfg.cfg_on    = CW'(on);
        cfg.cfg_off   = CW'(off);
        cfg.cfg_burst = 4'(burst);
    endtask

    task automatic frame(input int vis, input int blank);
        repeat (vis) begin i_vblnk = 1'b0; step(); end
        repeat (blank) begin i_vblnk = 1'b1; step(); end
    endtask

    initial begin
        int vis_left, blank_left;
        i_rst_n = 1'b0;
        i_vblnk = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_mode  = 2'b00;
        cfg.cfg_on    = '0;
        cfg.cfg_off   = '0;
        cfg.cfg_burst = 4'd0;
        model_reset();
        done_cnt = 0;
        done_frame = -1;

        tbl[0] = '{2, 2, 3, 0, 12'b110001100011, -1};
        tbl[1] = '{3, 1, 1, 3, 12'b000000010101,  6};
        tbl[2] = '{2, 0, 0, 0, 12'b010101010101, -1};
        tbl[3] = '{1, 5, 5, 0, 12'b111111111111, -1};
        tbl[4] = '{0, 5, 5, 0, 12'b000000000000, -1};
        tbl[5] = '{3, 2, 1, 0, 12'b000000000000,  0};
        tbl[6] = '{3, 1, 2, 2, 12'b000000001001,  6};

        // T1: reset held while vblank toggles
        repeat (6) begin i_vblnk = ~i_vblnk; step(); end
        i_rst_n = 1'b1;
        frame(5, 2);
        frame(5, 2);
        check("t1_blink_after_reset", o_blink, 1'b0);

        // T2/T3/T5 vectors: command mid-frame, then 12 frames recorded from the apply tick
        for (int i = 0; i < 7; i++) begin
            issue(tbl[i].mode, tbl[i].on, tbl[i].off, tbl[i].burst);
            i_vblnk = 1'b0;
            step();
            check("tbl_ready_drop", cfg.cfg_ready, 1'b0);
            rec.delete();
            done_cnt = 0;
            done_frame = -1;
            repeat (12) frame(6, 3);
            check("tbl_frames", rec.size(), 12);
            for (int j = 0; j < 12; j++)
                if (j < rec.size()) check($sformatf("tbl%0d_f%0d", i, j), rec[j], tbl[i].pat[j]);
            check($sformatf("tbl%0d_done_frame", i), done_frame, tbl[i].done_at);
            check($sformatf("tbl%0d_done_cnt", i), done_cnt, (tbl[i].done_at >= 0) ? 1 : 0);
        end

        // T4: command accepted on the tick cycle waits for the following tick
        i_vblnk = 1'b0;
        repeat (4) step();
        i_vblnk = 1'b1;
        issue(1, 1, 1, 0);
        step();
        check("t4_tick", o_frame_tick, 1'b1);
        check("t4_not_applied", o_blink, 1'b0);
        check("t4_ready_low", cfg.cfg_ready, 1'b0);
        issue(2, 1, 1, 0);
        repeat (2) begin step(); check("t4_hold", cfg.cfg_ready, 1'b0); end
        i_vblnk = 1'b0;
        repeat (3) step();
        i_vblnk = 1'b1;
        step();
        check("t4_applied", o_blink, 1'b1);
        check("t4_ready_back", cfg.cfg_ready, 1'b1);
        step();
        check("t4_second_acc", cfg.cfg_ready, 1'b0);
        frame(5, 3);
        check("t4_blink_on", o_blink, 1'b1);
        frame(5, 3);
        check("t4_blink_off", o_blink, 1'b0);

        // T5: STEADY issued during an off phase takes over at the next tick
        issue(2, 3, 3, 0);
        i_vblnk = 1'b0;
        step();
        repeat (4) frame(5, 2);
        issue(1, 0, 0, 0);
        i_vblnk = 1'b0;
        step();
        check("t5_pre", o_blink, 1'b0);
        repeat (3) begin frame(5, 2); check("t5_steady", o_blink, 1'b1); end

        // T6: asynchronous reset during BURST_ON with a command pending
        issue(3, 3, 3, 2);
        i_vblnk = 1'b0;
        step();
        frame(5, 2);
        frame(5, 2);
        check("t6_in_burst", o_blink, 1'b1);
        issue(2, 2, 2, 0);
        i_vblnk = 1'b0;
        step();
        check("t6_pending", cfg.cfg_ready, 1'b0);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("t6_async_blink", o_blink, 1'b0);
        check("t6_async_ready", cfg.cfg_ready, 1'b1);
        check("t6_async_done", o_done, 1'b0);
        cfg.cfg_valid = 1'b0;
        model_reset();
        done_cnt = 0;
        repeat (2) step();
        i_rst_n = 1'b1;
        repeat (3) frame(5, 2);
        check("t6_no_done", done_cnt, 0);
        check("t6_dropped", o_blink, 1'b0);

        // random traffic against the model
        vis_left = 0;
        blank_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (vis_left > 0) begin
                i_vblnk = 1'b0; vis_left--;
            end else if (blank_left > 0) begin
                i_vblnk = 1'b1; blank_left--;
            end else begin
                vis_left = $urandom_range(6, 1);
                blank_left = $urandom_range(3, 1);
                i_vblnk = 1'b0;
                vis_left--;
            end
            if (!cfg.cfg_valid && $urandom_range(15, 0) == 0)
                issue($urandom_range(3, 0), $urandom_range(4, 0), $urandom_range(4, 0), $urandom_range(3, 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
